// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared constants for the ALU and its two-port arbiter:
//   - ALU opcodes (ALU_*_OP)
//   - requester ids (ALU_REQ_EXEC, ALU_REQ_BRANCH)
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD_OP  = 4'd0;
    localparam logic [3:0] ALU_SUB_OP  = 4'd1;
    localparam logic [3:0] ALU_AND_OP  = 4'd2;
    localparam logic [3:0] ALU_OR_OP   = 4'd3;
    localparam logic [3:0] ALU_XOR_OP  = 4'd4;
    localparam logic [3:0] ALU_SLL_OP  = 4'd5;
    localparam logic [3:0] ALU_SRL_OP  = 4'd6;
    localparam logic [3:0] ALU_SRA_OP  = 4'd7;
    localparam logic [3:0] ALU_SLT_OP  = 4'd8;
    localparam logic [3:0] ALU_SLTU_OP = 4'd9;

    // Requester ids: port 0 is the execute stage, port 1 the branch/address unit
    localparam logic ALU_REQ_EXEC   = 1'b0;
    localparam logic ALU_REQ_BRANCH = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_arbiter_alu
//   Purely combinational ALU shared by the arbiter.
//   Ports:
//     a, b    [WIDTH-1:0]     operands
//     op      [OP_WIDTH-1:0]  opcode (ALU_*_OP)
//     result  [WIDTH-1:0]     result; unknown opcodes give 0
//   Add/sub wrap around, shift amount is b[4:0], SLT signed, SLTU unsigned.
// ---------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 4
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OP_WIDTH-1:0] op,
    output logic [WIDTH-1:0]    result
);

    logic [4:0] w_shamt;
    assign w_shamt = b[4:0];

    always_comb begin
        // NOTE: result gets a default before the case so no latch is inferred.
        result = '0;
        case (op)
            ALU_ADD_OP:  result = a + b;
            ALU_SUB_OP:  result = a - b;
            ALU_AND_OP:  result = a & b;
            ALU_OR_OP:   result = a | b;
            ALU_XOR_OP:  result = a ^ b;
            ALU_SLL_OP:  result = a << w_shamt;
            ALU_SRL_OP:  result = a >> w_shamt;
            ALU_SRA_OP:  result = WIDTH'($signed(a) >>> w_shamt);
            ALU_SLT_OP:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU_OP: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters with round-robin
//   arbitration. The granted requester's operands feed the ALU in the grant
//   cycle; the result lands in a one-entry register tagged with its owner and
//   is presented on that owner's response channel the following cycle.
//   Ports (x = 0 execute stage, x = 1 branch/address unit):
//     clock, reset          rising-edge clock, synchronous active-high reset
//     req_valid_x   in      operation offered
//     req_ready_x   out     operation accepted this cycle
//     req_a_x/b_x   in      operands [WIDTH-1:0]
//     req_op_x      in      opcode   [OP_WIDTH-1:0]
//     resp_valid_x  out     result available for requester x
//     resp_ready_x  in      requester x consumes the result
//     resp_result_x out     result (0 when resp_valid_x is low)
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_0,
    output logic                req_ready_0,
    input  logic [WIDTH-1:0]    req_a_0,
    input  logic [WIDTH-1:0]    req_b_0,
    input  logic [OP_WIDTH-1:0] req_op_0,
    output logic                resp_valid_0,
    input  logic                resp_ready_0,
    output logic [WIDTH-1:0]    resp_result_0,
    input  logic                req_valid_1,
    output logic                req_ready_1,
    input  logic [WIDTH-1:0]    req_a_1,
    input  logic [WIDTH-1:0]    req_b_1,
    input  logic [OP_WIDTH-1:0] req_op_1,
    output logic                resp_valid_1,
    input  logic                resp_ready_1,
    output logic [WIDTH-1:0]    resp_result_1
);

    logic             r_res_valid;
    logic             r_res_owner;
    logic [WIDTH-1:0] r_res_data;
    logic             r_last_grant;

    logic                w_owner_ready;
    logic                w_can_accept;
    logic                w_grant;
    logic                w_accept;
    logic [WIDTH-1:0]    w_alu_a;
    logic [WIDTH-1:0]    w_alu_b;
    logic [OP_WIDTH-1:0] w_alu_op;
    logic [WIDTH-1:0]    w_alu_result;

    // The slot frees up when it is empty or its owner drains it this cycle,
    // which lets a drain and a new accept share one cycle.
    assign w_owner_ready = (r_res_owner == ALU_REQ_BRANCH) ? resp_ready_1 : resp_ready_0;
    assign w_can_accept  = !r_res_valid || w_owner_ready;

    // A lone requester always wins; on conflict the one not granted last wins.
    always_comb begin
        w_grant = ALU_REQ_EXEC;
        if (req_valid_0 && req_valid_1) begin
            w_grant = ~r_last_grant;
        end else if (req_valid_1) begin
            w_grant = ALU_REQ_BRANCH;
        end
    end

    assign req_ready_0 = w_can_accept && (w_grant == ALU_REQ_EXEC)   && req_valid_0 && !reset;
    assign req_ready_1 = w_can_accept && (w_grant == ALU_REQ_BRANCH) && req_valid_1 && !reset;
    assign w_accept    = req_ready_0 || req_ready_1;

    // With no grant w_grant is 0, so requester 0 drives the ALU; the result
    // is simply not captured.
    assign w_alu_a  = (w_grant == ALU_REQ_BRANCH) ? req_a_1  : req_a_0;
    assign w_alu_b  = (w_grant == ALU_REQ_BRANCH) ? req_b_1  : req_b_0;
    assign w_alu_op = (w_grant == ALU_REQ_BRANCH) ? req_op_1 : req_op_0;

    alu_arbiter_alu #(
        .WIDTH    (WIDTH),
        .OP_WIDTH (OP_WIDTH)
    ) u_alu (
        .a      (w_alu_a),
        .b      (w_alu_b),
        .op     (w_alu_op),
        .result (w_alu_result)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_res_valid  <= 1'b0;
            r_res_owner  <= ALU_REQ_EXEC;
            r_res_data   <= '0;
            r_last_grant <= ALU_REQ_BRANCH;   // requester 0 wins the first conflict
        end else if (w_accept) begin
            r_res_valid  <= 1'b1;
            r_res_owner  <= w_grant;
            r_res_data   <= w_alu_result;
            r_last_grant <= w_grant;
        end else if (r_res_valid && w_owner_ready) begin
            r_res_valid  <= 1'b0;             // data left stale, never observable
        end
    end

    // Gated by reset so nothing leaks out before the first reset edge.
    assign resp_valid_0  = r_res_valid && (r_res_owner == ALU_REQ_EXEC)   && !reset;
    assign resp_valid_1  = r_res_valid && (r_res_owner == ALU_REQ_BRANCH) && !reset;
    assign resp_result_0 = resp_valid_0 ? r_res_data : '0;
    assign resp_result_1 = resp_valid_1 ? r_res_data : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed scenarios plus a randomized phase. Stimulus pushes expected
//   responses into a scoreboard; a negedge monitor compares whatever the DUT
//   presents on its response channels against the queue head.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        bit          owner;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rv  [2];
    logic [31:0] ra  [2];
    logic [31:0] rb  [2];
    logic [3:0]  rop [2];
    logic        rr  [2];

    logic        req_ready_0, req_ready_1;
    logic        resp_valid_0, resp_valid_1;
    logic [31:0] resp_result_0, resp_result_1;

    logic        resp_v [2];
    logic [31:0] resp_d [2];
    assign resp_v[0] = resp_valid_0;
    assign resp_v[1] = resp_valid_1;
    assign resp_d[0] = resp_result_0;
    assign resp_d[1] = resp_result_1;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: slot occupancy, owner, most recent grant.
    bit   m_busy  = 1'b0;
    bit   m_owner = 1'b0;
    bit   m_last  = 1'b1;
    bit   acc_last [2];

    always #5 clock = ~clock;

    alu_arbiter #(
        .WIDTH    (32),
        .OP_WIDTH (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid_0   (rv[0]),
        .req_ready_0   (req_ready_0),
        .req_a_0       (ra[0]),
        .req_b_0       (rb[0]),
        .req_op_0      (rop[0]),
        .resp_valid_0  (resp_valid_0),
        .resp_ready_0  (rr[0]),
        .resp_result_0 (resp_result_0),
        .req_valid_1   (rv[1]),
        .req_ready_1   (req_ready_1),
        .req_a_1       (ra[1]),
        .req_b_1       (rb[1]),
        .req_op_1      (rop[1]),
        .resp_valid_1  (resp_valid_1),
        .resp_ready_1  (rr[1]),
        .resp_result_1 (resp_result_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_ADD_OP:  return a + b;
            ALU_SUB_OP:  return a - b;
            ALU_AND_OP:  return a & b;
            ALU_OR_OP:   return a | b;
            ALU_XOR_OP:  return a ^ b;
            ALU_SLL_OP:  return a << sh;
            ALU_SRL_OP:  return a >> sh;
            ALU_SRA_OP: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            ALU_SLT_OP:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU_OP: return (a < b) ? 32'd1 : 32'd0;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        rv[i] = 1'b1; rop[i] = op; ra[i] = a; rb[i] = b;
    endtask

    task automatic new_req(input int i);
        set_req(i, 4'($urandom_range(0, 9)), rand_operand(), rand_operand());
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < 2; i++) if (acc_last[i]) rv[i] = 1'b0;
    endtask

    // One clock: at the negedge compare handshakes with the model, push any
    // expected response, advance the model; return at posedge + 1.
    task automatic cycle();
        bit can, g, acc;
        @(negedge clock);
        acc_last[0] = 1'b0;
        acc_last[1] = 1'b0;
        if (reset) begin
            check("rst_req_ready_0", {31'd0, req_ready_0}, 32'd0);
            check("rst_req_ready_1", {31'd0, req_ready_1}, 32'd0);
            check("rst_resp_valid_0", {31'd0, resp_valid_0}, 32'd0);
            check("rst_resp_valid_1", {31'd0, resp_valid_1}, 32'd0);
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
            sb.delete();
        end else begin
            can = !m_busy || rr[m_owner];
            g   = (rv[0] && rv[1]) ? !m_last : rv[1];
            acc = can && rv[g];
            check("req_ready_0", {31'd0, req_ready_0}, {31'd0, acc && !g});
            check("req_ready_1", {31'd0, req_ready_1}, {31'd0, acc && g});
            check("resp_valid_0", {31'd0, resp_valid_0}, {31'd0, m_busy && !m_owner});
            check("resp_valid_1", {31'd0, resp_valid_1}, {31'd0, m_busy && m_owner});
            if (acc) begin
                sb.push_back('{owner: g, data: alu_ref(rop[g], ra[g], rb[g])});
                acc_last[g] = 1'b1;
                m_busy = 1'b1; m_owner = g; m_last = g;
            end else if (m_busy && rr[m_owner]) begin
                m_busy = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: compares presented responses, pops on drain.
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (resp_v[i]) begin
                    check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        check("resp_owner", {31'd0, sb[0].owner}, i);
                        check("resp_result", resp_d[i], sb[0].data);
                        if (rr[i]) void'(sb.pop_front());
                    end
                end else begin
                    check("resp_result_idle", resp_d[i], 32'd0);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rop[i] = '0; rr[i] = 1'b0;
            acc_last[i] = 1'b0;
        end
        #1;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // 1. Single request, response next cycle.
        set_req(0, ALU_ADD_OP, 32'd10, 32'd10);
        rr[0] = 1'b1;
        #1 check("t1_ready_same_cycle", {31'd0, req_ready_0}, 32'd1);
        cycle(); drop_accepted();
        check("t1_resp_valid_0", {31'd0, resp_valid_0}, 32'd1);
        check("t1_resp_result_0", resp_result_0, 32'd20);
        check("t1_resp_valid_1", {31'd0, resp_valid_1}, 32'd0);
        cycle();

        // 2. Conflict right after reset: requester 0 first.
        reset = 1'b1; cycle(); reset = 1'b0;
        set_req(0, ALU_SUB_OP, 32'd10, 32'd20);
        set_req(1, ALU_SLT_OP, 32'd20, 32'd30);
        rr[0] = 1'b1; rr[1] = 1'b1;
        #1 check("t2_first_grant", {30'd0, req_ready_1, req_ready_0}, 32'd1);
        cycle(); drop_accepted();
        check("t2_resp_result_0", resp_result_0, 32'hFFFF_FFF6);
        check("t2_second_grant", {30'd0, req_ready_1, req_ready_0}, 32'd2);
        cycle(); drop_accepted();
        check("t2_resp_result_1", resp_result_1, 32'd1);
        cycle();

        // 3. Fairness: alternating grants, one response per cycle.
        new_req(0); new_req(1);
        for (int k = 0; k < 6; k++) begin
            #1 check("t3_grant_seq", {30'd0, req_ready_1, req_ready_0}, (k % 2) ? 32'd2 : 32'd1);
            if (k > 0) check("t3_resp_per_cycle", {30'd0, resp_valid_1, resp_valid_0},
                             (k % 2) ? 32'd1 : 32'd2);
            cycle();
            for (int i = 0; i < 2; i++) if (acc_last[i]) new_req(i);
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        cycle();

        // 4. Backpressure holds the response and blocks both requesters.
        set_req(1, ALU_SRA_OP, 32'hFFFF_FFF0, 32'd4);
        rr[1] = 1'b0;
        cycle(); drop_accepted();
        set_req(0, ALU_SLTU_OP, 32'hFFFF_FFE2, 32'd20);
        rr[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_held_result_1", resp_result_1, 32'hFFFF_FFFF);
            check("t4_blocked", {30'd0, req_ready_1, req_ready_0}, 32'd0);
            cycle();
        end
        rr[1] = 1'b1;
        #1 check("t4_accept_on_drain", {31'd0, req_ready_0}, 32'd1);
        cycle(); drop_accepted();
        check("t4_resp_valid_0", {31'd0, resp_valid_0}, 32'd1);
        check("t4_resp_result_0", resp_result_0, 32'd0);
        check("t4_resp_valid_1", {31'd0, resp_valid_1}, 32'd0);
        cycle();

        // 5. Reset discards a pending result.
        set_req(1, ALU_ADD_OP, 32'd1, 32'd2);
        rr[1] = 1'b0;
        cycle(); drop_accepted();
        check("t5_pending", {31'd0, resp_valid_1}, 32'd1);
        set_req(0, ALU_XOR_OP, 32'h1234_5678, 32'hFFFF_0000);
        reset = 1'b1;
        #1 check("t5_ready_in_reset", {31'd0, req_ready_0}, 32'd0);
        cycle();
        reset = 1'b0;
        check("t5_discarded", {31'd0, resp_valid_1}, 32'd0);
        set_req(1, ALU_OR_OP, 32'h0F0F_0000, 32'h0000_F0F0);
        rr[0] = 1'b1; rr[1] = 1'b1;
        #1 check("t5_conflict_req0", {30'd0, req_ready_1, req_ready_0}, 32'd1);
        cycle(); drop_accepted();
        cycle(); drop_accepted();
        cycle();

        // 6. Idle cycles do not move priority.
        set_req(1, ALU_SLL_OP, 32'h0000_0001, 32'd31);
        cycle(); drop_accepted();
        for (int k = 0; k < 5; k++) cycle();
        set_req(0, ALU_AND_OP, 32'hF0F0_F0F0, 32'hFFFF_0000);
        set_req(1, ALU_SRL_OP, 32'h8000_0000, 32'd31);
        #1 check("t6_idle_priority", {30'd0, req_ready_1, req_ready_0}, 32'd1);
        cycle(); drop_accepted();
        cycle(); drop_accepted();
        cycle();

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) new_req(i);
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
            drop_accepted();
        end

        // Drain and confirm every expected response was seen.
        rv[0] = 1'b0; rv[1] = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the existing combinational `alu` between two requesters: port 0 is the execute stage, port 1 is the branch/address unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands are presented to the ALU combinationally on the grant cycle, and the result is captured in a one-entry output register tagged with the owner.
- Throughput is one operation per cycle when the owner drains its response.

Parameters:
- WIDTH, 32, operand and result width.
- OP_WIDTH, 4, ALU opcode width; opcodes are the shared `ALU_*_OP defines.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid_0  input  1  requester 0 has an operation.
- req_ready_0  output  1  requester 0 operation accepted this cycle.
- req_a_0  input  WIDTH  requester 0 operand a.
- req_b_0  input  WIDTH  requester 0 operand b.
- req_op_0  input  OP_WIDTH  requester 0 opcode.
- resp_valid_0  output  1  result for requester 0 available.
- resp_ready_0  input  1  requester 0 consumes the result.
- resp_result_0  output  WIDTH  result for requester 0.
- req_valid_1, req_ready_1, req_a_1, req_b_1, req_op_1, resp_valid_1, resp_ready_1, resp_result_1: same as the _0 ports, for requester 1.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named `clock` and `reset`.
- State:
  - res_valid (1 bit), res_owner (1 bit), res_data (WIDTH bits).
  - last_grant (1 bit), the id of the requester granted most recently.
- Reset values (applied at the first rising edge with reset=1):
  - res_valid=0, res_owner=0, res_data=0.
  - last_grant=1, so requester 0 wins the first conflict.
- Outputs while reset is asserted: resp_valid_* = 0 and req_ready_* = 0.
- can_accept = !res_valid OR (resp_ready of res_owner, sampled while res_valid=1). The drain and a new accept may occur in the same cycle.
- Grant (combinational):
  - Only one requester valid: grant it.
  - Both valid: grant !last_grant.
  - req_ready_i = can_accept AND grant==i AND req_valid_i AND !reset.
  - At most one req_ready is high per cycle.
- ALU input mux: drives a/b/op from the granted requester. With no grant it selects requester 0; the result is ignored.
- On accept (rising edge with some req_ready_i=1):
  - res_data <= alu.result, res_owner <= i, res_valid <= 1, last_grant <= i.
- On drain without accept: res_valid <= 0. res_data keeps its old value and is not observable.
- Response outputs:
  - resp_valid_i = res_valid AND res_owner==i.
  - resp_result_i = res_data when resp_valid_i, else 0.
- Latency: a request accepted in cycle N has its response valid in cycle N+1. The response is held stable until the owner's resp_ready is high.
- Backpressure: while res_valid=1 and the owner's resp_ready=0, both req_ready are 0. Requesters must hold req_* stable until accepted.
- last_grant updates only on accept. Idle cycles do not move priority.
- Arithmetic is entirely inside `alu`: wrap-around add/sub, shift amount = b[4:0], SLT signed, SLTU unsigned. The arbiter adds no width conversion.
- Reset mid-operation: a pending result is discarded with no response. In-flight requesters must re-present after reset.
- The response of requester i may be drained in the same cycle that requester 1-i is accepted.
- resp_ready_i while resp_valid_i=0 is ignored.

Decomposition:
- Opcodes: the existing shared `ALU_*_OP defines header. No new opcode constants.
- Add to the same shared header: ALU_REQ_EXEC=0 and ALU_REQ_BRANCH=1 (requester ids).
- Single sub-module: one instance of the existing `alu` (a, b, op, result). Grant logic and result register stay inline.

Test Plan:
1. Single request: reset, then req_valid_0=1, a=10, b=10, op=ALU_ADD_OP -> req_ready_0=1 the same cycle; next cycle resp_valid_0=1, resp_result_0=20, resp_valid_1=0.
2. Conflict after reset: req0 (SUB 10,20) and req1 (SLT 20,30) both valid, both resp_ready=1 -> cycle 0 grants req0; cycle 1 resp_result_0=32'hFFFFFFF6 and req1 is granted; cycle 2 resp_result_1=1.
3. Fairness: both requesters valid for 6 cycles, resp_ready=1 -> grant sequence 0,1,0,1,0,1 and one response per cycle.
4. Backpressure: req1 SRA a=32'hFFFFFFF0, b=4 with resp_ready_1=0 for 3 cycles -> resp_result_1=32'hFFFFFFFF held stable and req_ready_0=req_ready_1=0 throughout. When resp_ready_1 goes high, a waiting req0 (SLTU -30,20) is accepted that same cycle, and next cycle resp_result_0=0.
5. Reset mid-operation: pending result for req1 with resp_ready_1=0, then reset one cycle -> resp_valid_1=0 the cycle after. A subsequent conflict grants req0 first.
6. Idle priority: grant req1 alone, idle 5 cycles, then both requesters valid -> req0 is granted, because last_grant did not move while idle.
